synaptic_current_gen: RTL

- Spike-to-current converter at the receiving end of the neuron interface. It consumes presynaptic spike strobes and produces the signed fixed-point input current `i` that drives the next neuron core.
- Models a single exponentially decaying conductance with a reversal potential.
- Updated once per simulation step, on the same `apply` strobe that steps the neuron cores.
- Sits between a presynaptic neuron's `is_spiking` and a postsynaptic neuron's `i`/`voltage`.

---
 rtl/snn_fixed_pkg.sv | 20 ++
 rtl/fxp_mult.sv | 41 ++++
 rtl/synaptic_current_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/snn_fixed_pkg.sv
// Shared fixed-point definitions for the spiking-network datapath: default
// word/fraction widths, the synapse update FSM states and clamp constants.
package snn_fixed_pkg;

  localparam int DEFAULT_N = 32;
  localparam int DEFAULT_Q = 16;

  typedef enum logic [2:0] {
    IDLE,
    DECAY,
    INJECT,
    DRIVE,
    DONE
  } state_t;

  // Clamp limits at the default word width.
  localparam logic [DEFAULT_N-1:0] SAT_MAX = {1'b0, {(DEFAULT_N-1){1'b1}}};
  localparam logic [DEFAULT_N-1:0] SAT_MIN = {1'b1, {(DEFAULT_N-1){1'b0}}};

endpackage

// File: rtl/fxp_mult.sv
// Combinational Q-format signed multiply: full product, >>> Q, truncate to N.
// Optional clamping to the signed N-bit range when SATURATE_EN is defined.
module fxp_mult
  import snn_fixed_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int Q = DEFAULT_Q
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);

  logic signed [2*N-1:0] a_ext;
  logic signed [2*N-1:0] b_ext;
  logic signed [2*N-1:0] prod;
  logic                  unused_lsb;

  assign a_ext      = {{N{a[N-1]}}, a};
  assign b_ext      = {{N{b[N-1]}}, b};
  assign prod       = a_ext * b_ext;
  assign unused_lsb = ^prod[Q-1:0];

`ifdef SATURATE_EN
  localparam logic [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    p = prod[Q +: N];
    // The result fits only if every bit above it matches the product sign.
    if (prod[2*N-1:Q+N-1] != {(N-Q+1){prod[2*N-1]}})
      p = prod[2*N-1] ? MIN_V : MAX_V;
  end
`else
  logic unused_msb;
  assign unused_msb = ^prod[2*N-1:Q+N];
  assign p          = prod[Q +: N];
`endif

endmodule

// File: rtl/synaptic_current_gen.sv
// Spike-to-current synapse: decaying conductance g stepped on apply, driving
// i = g*(e_rev - v_post). Define SATURATE_EN to clamp instead of wrap.
module synaptic_current_gen
  import snn_fixed_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int Q  = DEFAULT_Q,
  parameter int CW = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         spike_in,
  input  logic         apply,
  input  logic [N-1:0] weight,
  input  logic [N-1:0] decay,
  input  logic [N-1:0] e_rev,
  input  logic [N-1:0] v_post,
  output logic         busy,
  output logic         i_valid,
  output logic [N-1:0] g,
  output logic [N-1:0] i
);

  state_t        state;
  logic [CW-1:0] pend;
  logic [CW-1:0] snap;
  logic [N-1:0]  mult_b;
  logic [N-1:0]  mult_p;
  logic [N-1:0]  diff;
  logic [N-1:0]  inj;
  logic [N-1:0]  inj_sum;

  // One multiplier serves both DECAY (g*decay) and DRIVE (g*diff).
  assign mult_b = (state == DRIVE) ? diff : decay;

  fxp_mult #(.N(N), .Q(Q)) u_mult (
    .a (g),
    .b (mult_b),
    .p (mult_p)
  );

`ifdef SATURATE_EN
  localparam logic [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

  logic [N:0]           diff_w;
  logic [N:0]           sum_w;
  logic signed [N+CW:0] w_ext;
  logic signed [N+CW:0] s_ext;
  logic signed [N+CW:0] inj_w;

  // One extra bit exposes overflow: the top two bits disagree.
  assign diff_w = {e_rev[N-1], e_rev} - {v_post[N-1], v_post};
  assign diff   = (diff_w[N] != diff_w[N-1]) ? (diff_w[N] ? MIN_V : MAX_V)
                                             : diff_w[N-1:0];

  assign w_ext  = {{(CW+1){weight[N-1]}}, weight};
  assign s_ext  = {{(N+1){1'b0}}, snap};
  assign inj_w  = w_ext * s_ext;
  assign inj    = (inj_w[N+CW:N-1] != {(CW+2){inj_w[N+CW]}})
                ? (inj_w[N+CW] ? MIN_V : MAX_V) : inj_w[N-1:0];

  assign sum_w   = {g[N-1], g} + {inj[N-1], inj};
  assign inj_sum = (sum_w[N] != sum_w[N-1]) ? (sum_w[N] ? MIN_V : MAX_V)
                                            : sum_w[N-1:0];
`else
  assign diff    = e_rev - v_post;
  assign inj     = weight * {{(N-CW){1'b0}}, snap};
  assign inj_sum = g + inj;
`endif

  // NOTE: state in always_ff uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pend    <= '0;
      snap    <= '0;
      g       <= '0;
      i       <= '0;
      busy    <= 1'b0;
      i_valid <= 1'b0;
    end else begin
      i_valid <= 1'b0;

      // A spike on the accept cycle belongs to the next step.
      if (state == IDLE && apply)
        pend <= CW'(spike_in);
      else if (spike_in && pend != {CW{1'b1}})
        pend <= pend + 1'b1;

      case (state)
        IDLE: begin
          if (apply) begin
            snap  <= pend;
            busy  <= 1'b1;
            state <= DECAY;
          end
        end
        DECAY: begin
          g     <= mult_p;
          state <= INJECT;
        end
        INJECT: begin
          g     <= inj_sum;
          state <= DRIVE;
        end
        DRIVE: begin
          i       <= mult_p;
          i_valid <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
